// File: rtl/ltc2308_serial_if.sv
// LTC2308 serial front end: one CONVST/conversion/shift frame per accepted measure_start.
// The 12-bit word shifted in belongs to the previous conversion; the SDI config applies to the next.
module ltc2308_serial_if #(
    parameter int CONVST_CYCLES = 2,
    parameter int CONV_CYCLES   = 64,
    parameter int SCK_HALF      = 2,
    parameter bit UNI           = 1'b1,
    parameter bit SLP           = 1'b0
) (
    input  logic        adc_clk,
    input  logic        adc_reset,
    input  logic        measure_start,
    input  logic [2:0]  measure_ch,
    output logic        measure_done,
    output logic [11:0] measure_dataread,
    output logic        ADC_CONVST,
    output logic        ADC_SCK,
    output logic        ADC_SDI,
    input  logic        ADC_SDO
);

    localparam int CNT_MAX = (CONV_CYCLES > SCK_HALF) ? CONV_CYCLES : SCK_HALF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CONVST_END = CNT_W'(CONVST_CYCLES);
    localparam logic [CNT_W-1:0] CONV_END   = CNT_W'(CONV_CYCLES);
    localparam logic [CNT_W-1:0] HALF_END   = CNT_W'(SCK_HALF);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        bit_cnt;
    logic [5:0]        cfg_sr;
    logic [11:0]       data_sr;
    logic              half_end;

    always_ff @(posedge adc_clk or posedge adc_reset) begin
        if (adc_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        half_end   = (cnt == HALF_END);
        case (state)
            IDLE:    if (measure_start) state_next = CONV;
            CONV:    if (cnt == CONV_END) state_next = SHIFT;
            SHIFT:   if (half_end && ADC_SCK && (bit_cnt == 4'd11)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // cnt counts cycles since the accepting edge in CONV, and cycles within an SCK half in SHIFT
    always_ff @(posedge adc_clk or posedge adc_reset) begin
        if (adc_reset) begin
            cnt              <= '0;
            bit_cnt          <= '0;
            cfg_sr           <= '0;
            data_sr          <= '0;
            measure_done     <= 1'b0;
            measure_dataread <= '0;
            ADC_CONVST       <= 1'b0;
            ADC_SCK          <= 1'b0;
            ADC_SDI          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (measure_start) begin
                        cnt          <= CNT_ONE;
                        cfg_sr       <= {1'b1, measure_ch[0], measure_ch[2], measure_ch[1], UNI, SLP};
                        measure_done <= 1'b0;
                        ADC_CONVST   <= 1'b1;
                    end
                end
                CONV: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CONVST_END) ADC_CONVST <= 1'b0;
                    if (cnt == CONV_END) begin
                        cnt     <= CNT_ONE;
                        bit_cnt <= '0;
                        ADC_SDI <= cfg_sr[5];
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        cnt <= CNT_ONE;
                        if (!ADC_SCK) begin
                            ADC_SCK <= 1'b1;
                            data_sr <= {data_sr[10:0], ADC_SDO};
                        end else begin
                            // cfg_sr drains to zeros, so SDI is 0 after the six config bits
                            ADC_SCK <= 1'b0;
                            ADC_SDI <= cfg_sr[4];
                            cfg_sr  <= {cfg_sr[4:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    measure_dataread <= data_sr;
                    measure_done     <= 1'b1;
                    ADC_SDI          <= 1'b0;
                    cnt              <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ltc2308_serial_if.sv
// Bench for ltc2308_serial_if: LTC2308 SDO model, scoreboard of expected data/config per frame.
module tb_ltc2308_serial_if;

    localparam int SCK_HALF = 2;
    localparam int LATENCY  = 113;

    logic        adc_clk = 1'b0;
    logic        adc_reset;
    logic        measure_start;
    logic [2:0]  measure_ch;
    logic        measure_done;
    logic [11:0] measure_dataread;
    logic        ADC_CONVST;
    logic        ADC_SCK;
    logic        ADC_SDI;
    logic        ADC_SDO;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_data_q[$];
    logic [5:0]  exp_cfg_q[$];
    logic [11:0] pending_val = 12'hA5C;
    logic [11:0] prev_val    = 12'hA5C;
    logic [11:0] frame_val   = 12'h000;
    logic [11:0] sdo_sr      = 12'h000;

    localparam logic [5:0] CFG_TBL [8] = '{6'b100010, 6'b110010, 6'b100110, 6'b110110,
                                           6'b101010, 6'b111010, 6'b101110, 6'b111110};
    localparam logic [11:0] VAL_TBL [16] = '{12'h123, 12'h456, 12'h789, 12'hABC,
                                             12'hDEF, 12'h0F0, 12'hF0F, 12'h5A5,
                                             12'h001, 12'h800, 12'hFFF, 12'h000,
                                             12'h3C3, 12'hC3C, 12'h777, 12'h888};

    ltc2308_serial_if dut (
        .adc_clk          (adc_clk),
        .adc_reset        (adc_reset),
        .measure_start    (measure_start),
        .measure_ch       (measure_ch),
        .measure_done     (measure_done),
        .measure_dataread (measure_dataread),
        .ADC_CONVST       (ADC_CONVST),
        .ADC_SCK          (ADC_SCK),
        .ADC_SDI          (ADC_SDI),
        .ADC_SDO          (ADC_SDO)
    );

    always #5 adc_clk = ~adc_clk;

    assign ADC_SDO = sdo_sr[11];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ADC model and frame monitor, sampled on the falling clock edge
    logic        convst_q = 1'b0;
    logic        sck_q    = 1'b0;
    logic        done_q   = 1'b0;
    int          rises    = 0;
    int          convst_hi = 0;
    int          lat      = 0;
    int          half_len = 0;
    int          width_bad = 0;
    logic [11:0] sdi_cap  = 12'h000;

    always @(negedge adc_clk) begin
        if (ADC_CONVST === 1'b1 && !convst_q) begin
            sdo_sr      = pending_val;
            pending_val = frame_val;
            rises       = 0;
            convst_hi   = 0;
            lat         = 0;
            width_bad   = 0;
            sdi_cap     = 12'h000;
        end else begin
            lat++;
        end
        if (ADC_CONVST === 1'b1) convst_hi++;
        if (ADC_SCK !== sck_q) begin
            if (ADC_SCK === 1'b1) begin
                if (rises > 0 && half_len != SCK_HALF) width_bad++;
                if (rises < 12) sdi_cap[11 - rises] = ADC_SDI;
                rises++;
            end else begin
                if (half_len != SCK_HALF) width_bad++;
                sdo_sr = {sdo_sr[10:0], 1'b0};
            end
            half_len = 1;
        end else begin
            half_len++;
        end
        if (measure_done === 1'b1 && !done_q) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with no accepted start, required none");
            end else begin
                check("dataread", measure_dataread, exp_data_q.pop_front());
                check("sdi_frame", sdi_cap, {exp_cfg_q.pop_front(), 6'b000000});
                check("sck_rises", 12'(rises), 12'd12);
                check("convst_width", 12'(convst_hi), 12'd2);
                check("done_latency", 12'(lat), 12'(LATENCY));
                check("sck_half_width_errs", 12'(width_bad), 12'd0);
            end
        end
        convst_q = (ADC_CONVST === 1'b1);
        sck_q    = ADC_SCK;
        done_q   = (measure_done === 1'b1);
    end

    task automatic do_start(input logic [2:0] ch, input logic [11:0] val);
        measure_ch    = ch;
        measure_start = 1'b1;
        frame_val     = val;
        exp_data_q.push_back(prev_val);
        exp_cfg_q.push_back(CFG_TBL[ch]);
        prev_val = val;
        @(posedge adc_clk);
        #1;
        measure_start = 1'b0;
        check("done_clear_on_start", {11'd0, measure_done}, 12'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (measure_done !== 1'b1 && n < 400) begin
            @(negedge adc_clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles, required done", n);
        end
    endtask

    initial begin
        adc_reset     = 1'b1;
        measure_start = 1'b0;
        measure_ch    = 3'd0;
        repeat (3) @(posedge adc_clk);
        #1;
        check("rst_done", {11'd0, measure_done}, 12'd0);
        check("rst_data", measure_dataread, 12'd0);
        check("rst_convst", {11'd0, ADC_CONVST}, 12'd0);
        check("rst_sck", {11'd0, ADC_SCK}, 12'd0);
        check("rst_sdi", {11'd0, ADC_SDI}, 12'd0);
        adc_reset = 1'b0;
        repeat (2) @(negedge adc_clk);

        // all eight channels, first frame returns the power-up conversion 12'hA5C
        for (int i = 0; i < 8; i++) begin
            do_start(3'(i), VAL_TBL[i]);
            wait_done();
        end
        repeat (5) @(negedge adc_clk);
        check("done_held", {11'd0, measure_done}, 12'd1);

        // starts while busy are dropped
        do_start(3'd2, 12'h5C3);
        repeat (9) @(posedge adc_clk);
        #1;
        measure_ch    = 3'd5;
        measure_start = 1'b1;
        @(posedge adc_clk);
        #1;
        measure_start = 1'b0;
        repeat (69) @(posedge adc_clk);
        #1;
        measure_start = 1'b1;
        @(posedge adc_clk);
        #1;
        measure_start = 1'b0;
        wait_done();
        repeat (150) @(negedge adc_clk);
        check("idle_after_busy_convst", {11'd0, ADC_CONVST}, 12'd0);
        check("idle_after_busy_done", {11'd0, measure_done}, 12'd1);

        // reset while SCK is high mid-shift
        do_start(3'd7, 12'h9E1);
        repeat (82) @(posedge adc_clk);
        #1;
        adc_reset = 1'b1;
        #1;
        check("abort_convst", {11'd0, ADC_CONVST}, 12'd0);
        check("abort_sck", {11'd0, ADC_SCK}, 12'd0);
        check("abort_sdi", {11'd0, ADC_SDI}, 12'd0);
        check("abort_done", {11'd0, measure_done}, 12'd0);
        void'(exp_data_q.pop_back());
        void'(exp_cfg_q.pop_back());
        repeat (3) @(posedge adc_clk);
        #1;
        adc_reset = 1'b0;
        repeat (150) @(negedge adc_clk);
        check("post_abort_done", {11'd0, measure_done}, 12'd0);
        check("post_abort_sck", {11'd0, ADC_SCK}, 12'd0);
        do_start(3'd3, 12'h246);
        wait_done();

        // back-to-back controller loop, start issued in the cycle done is seen
        for (int i = 0; i < 16; i++) begin
            do_start(3'(i % 8), VAL_TBL[15 - i]);
            wait_done();
        end

        repeat (20) @(negedge adc_clk);
        check("scoreboard_empty", 12'(exp_data_q.size()), 12'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
